// File: rtl/axi4_slave_sram_if.sv
// rtl/axi4_slave_sram_if.sv - AXI4 write/read channel bundle between a master and the SRAM slave
interface axi4_slave_sram_if #(
    parameter int C_ID_WIDTH   = 2,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 512
);
    localparam int NB = C_DATA_WIDTH / 8;

    logic [C_ID_WIDTH-1:0]   AWID;
    logic [C_ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]              AWLEN;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [C_DATA_WIDTH-1:0] WDATA;
    logic [NB-1:0]           WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [C_ID_WIDTH-1:0]   BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [C_ID_WIDTH-1:0]   ARID;
    logic [C_ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]              ARLEN;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [C_ID_WIDTH-1:0]   RID;
    logic [C_DATA_WIDTH-1:0] RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );
endinterface

// File: rtl/axi4_slave_sram.sv
// rtl/axi4_slave_sram.sv - AXI4 INCR-burst slave over dual-port SRAM; AXI4_SRAM_RANGE_CHECK_EN flags beats past the SRAM depth
module axi4_slave_sram #(
    parameter int C_ID_WIDTH       = 2,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = 512,
    parameter int C_MEM_DEPTH_LOG2 = 10
) (
    input logic              CLK,
    input logic              nRST,
    axi4_slave_sram_if.slave bus
);
    localparam int NB    = C_DATA_WIDTH / 8;
    localparam int LNB   = $clog2(NB);
    localparam int IW    = C_ADDR_WIDTH - LNB;
    localparam int DEPTH = 1 << C_MEM_DEPTH_LOG2;
    localparam logic [IW-1:0] IDX_ONE = 1;
`ifdef AXI4_SRAM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    // Full beat index is kept so beats that wrapped past the top row stay detectable.
    function automatic logic out_of_range(input logic [IW-1:0] idx);
        return RANGE_CHECK && (idx[IW-1:C_MEM_DEPTH_LOG2] != '0);
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [C_DATA_WIDTH-1:0] mem [DEPTH];
    logic [C_DATA_WIDTH-1:0] rd_q;
    logic                    ready_en;

    w_state_t              w_state, w_state_nxt;
    logic [C_ID_WIDTH-1:0] w_id;
    logic [IW-1:0]         w_idx;
    logic [7:0]            w_len, w_cnt;
    logic                  w_err;
    logic                  aw_fire, w_fire, w_beat_err, w_mem_we;

    r_state_t              r_state, r_state_nxt;
    logic [C_ID_WIDTH-1:0] r_id;
    logic [IW-1:0]         r_idx, rd_idx;
    logic [7:0]            r_len, r_cnt;
    logic                  r_oor, ar_fire, r_fire, r_last, rd_en;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.AWADDR[LNB-1:0], bus.ARADDR[LNB-1:0]};

    assign aw_fire  = bus.AWVALID && ready_en && (w_state == W_IDLE);
    assign w_fire   = bus.WVALID && (w_state == W_DATA);
    // Too few beats (early WLAST) or too many (no WLAST at LEN) both poison the response.
    assign w_beat_err = (bus.WLAST ? (w_cnt != w_len) : (w_cnt == w_len)) || out_of_range(w_idx);
    assign w_mem_we = w_fire && !out_of_range(w_idx);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
            W_DATA:  if (w_fire && bus.WLAST) w_state_nxt = W_RESP;
            W_RESP:  if (bus.BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ready_en <= 1'b0;
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_idx    <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            w_state  <= w_state_nxt;
            if (aw_fire) begin
                w_id  <= bus.AWID;
                w_idx <= bus.AWADDR[C_ADDR_WIDTH-1:LNB];
                w_len <= bus.AWLEN;
                w_cnt <= '0;
                w_err <= 1'b0;
            end else if (w_fire) begin
                w_idx <= w_idx + IDX_ONE;
                w_cnt <= w_cnt + 8'd1;
                w_err <= w_err | w_beat_err;
            end
        end
    end

    assign ar_fire = bus.ARVALID && ready_en && (r_state == R_IDLE);
    assign r_fire  = (r_state == R_DATA) && bus.RREADY;
    assign r_last  = (r_cnt == r_len);

    always_comb begin
        r_state_nxt = r_state;
        rd_en       = 1'b0;
        rd_idx      = r_idx + IDX_ONE;
        case (r_state)
            R_IDLE: if (ar_fire) begin
                rd_en       = 1'b1;
                rd_idx      = bus.ARADDR[C_ADDR_WIDTH-1:LNB];
                r_state_nxt = R_DATA;
            end
            R_DATA: if (r_fire) begin
                if (r_last) r_state_nxt = R_IDLE;
                else        rd_en       = 1'b1;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_fire) begin
                r_id  <= bus.ARID;
                r_len <= bus.ARLEN;
                r_cnt <= '0;
            end else if (r_fire) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (rd_en) begin
                r_idx <= rd_idx;
                r_oor <= out_of_range(rd_idx);
            end
        end
    end

    // Contents are not reset; the read register samples old data on a same-row write.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.WSTRB[b]) mem[w_idx[C_MEM_DEPTH_LOG2-1:0]][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
            end
        end
        if (rd_en) rd_q <= mem[rd_idx[C_MEM_DEPTH_LOG2-1:0]];
    end

    assign bus.AWREADY = ready_en && (w_state == W_IDLE);
    assign bus.WREADY  = (w_state == W_DATA);
    assign bus.BVALID  = (w_state == W_RESP);
    assign bus.BID     = w_id;
    assign bus.BRESP   = (bus.BVALID && w_err) ? 2'b10 : 2'b00;

    assign bus.ARREADY = ready_en && (r_state == R_IDLE);
    assign bus.RVALID  = (r_state == R_DATA);
    assign bus.RID     = r_id;
    assign bus.RLAST   = bus.RVALID && r_last;
    assign bus.RRESP   = (bus.RVALID && r_oor) ? 2'b10 : 2'b00;
    assign bus.RDATA   = (bus.RVALID && !r_oor) ? rd_q : '0;
endmodule

// File: tb/tb_axi4_slave_sram.sv
// tb/tb_axi4_slave_sram.sv - directed bench for axi4_slave_sram
module tb_axi4_slave_sram;
    localparam int IDW = 2;
    localparam int AW  = 32;
    localparam int DW  = 512;
    localparam int DL  = 10;
    localparam int NB  = DW / 8;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    axi4_slave_sram_if #(.C_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    axi4_slave_sram #(
        .C_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MEM_DEPTH_LOG2(DL)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] wbuf  [256];
    logic [NB-1:0] sbuf  [256];
    logic [DW-1:0] rexp  [256];
    logic [1:0]    rrexp [256];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {16{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic aw_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        int t;
        t = 0;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWVALID = 1'b1;
        while (!bus.AWREADY && t < 100) begin @(negedge CLK); t++; end
        if (t >= 100) check("aw_timeout", 1, 0);
        @(negedge CLK);
        bus.AWVALID = 1'b0;
    endtask

    task automatic w_burst(input int n, input int last_at);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            bus.WDATA = wbuf[i]; bus.WSTRB = sbuf[i]; bus.WLAST = (i == last_at); bus.WVALID = 1'b1;
            while (!bus.WREADY && t < 100) begin @(negedge CLK); t++; end
            if (t >= 100) check("w_timeout", 1, 0);
            @(negedge CLK);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
    endtask

    task automatic b_recv(input logic [IDW-1:0] id, input logic [1:0] resp, input string tag);
        int t;
        t = 0;
        bus.BREADY = 1'b1;
        while (!bus.BVALID && t < 100) begin @(negedge CLK); t++; end
        if (t >= 100) check({tag, "_b_timeout"}, 1, 0);
        check({tag, "_bid"}, bus.BID, id);
        check({tag, "_bresp"}, bus.BRESP, resp);
        @(negedge CLK);
        bus.BREADY = 1'b0;
    endtask

    task automatic ar_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           output logic rvalid_at_hs);
        int t;
        t = 0;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARVALID = 1'b1;
        while (!bus.ARREADY && t < 100) begin @(negedge CLK); t++; end
        if (t >= 100) check("ar_timeout", 1, 0);
        rvalid_at_hs = bus.RVALID;
        @(negedge CLK);
        bus.ARVALID = 1'b0;
    endtask

    task automatic r_recv(input int n, input bit toggle, input logic [IDW-1:0] id, input string tag);
        int got, cyc;
        logic rdy, have_held;
        logic [DW-1:0] held;
        got = 0; cyc = 0; have_held = 1'b0; held = '0;
        while (got < n && cyc < 2000) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.RREADY = rdy;
            if (bus.RVALID) begin
                if (have_held) check({tag, "_hold"}, bus.RDATA, held);
                if (rdy) begin
                    check($sformatf("%s_rdata%0d", tag, got), bus.RDATA, rexp[got]);
                    check($sformatf("%s_rresp%0d", tag, got), bus.RRESP, rrexp[got]);
                    check($sformatf("%s_rlast%0d", tag, got), bus.RLAST, (got == n - 1));
                    check($sformatf("%s_rid%0d", tag, got), bus.RID, id);
                    got++;
                    have_held = 1'b0;
                end else begin
                    held = bus.RDATA;
                    have_held = 1'b1;
                end
            end
            @(negedge CLK);
            cyc++;
        end
        bus.RREADY = 1'b0;
        check({tag, "_beats"}, got, n);
        if (!toggle) check({tag, "_cycles"}, cyc, n);
        check({tag, "_rvalid_end"}, bus.RVALID, 0);
        check({tag, "_arready_end"}, bus.ARREADY, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rv_hs;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        for (int i = 0; i < 256; i++) begin sbuf[i] = '1; rrexp[i] = 2'b00; end

        repeat (3) @(negedge CLK);
        check("rst_awready", bus.AWREADY, 0);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rdata", bus.RDATA, 0);
        nRST = 1'b1;
        #1;
        check("rel_awready_same", bus.AWREADY, 0);
        @(negedge CLK);
        check("rel_awready", bus.AWREADY, 1);
        check("rel_arready", bus.ARREADY, 1);

        // single beat
        wbuf[0] = pat(100);
        aw_send(2'd2, 32'h40, 8'd0);
        w_burst(1, 0);
        b_recv(2'd2, 2'b00, "single");
        ar_send(2'd1, 32'h40, 8'd0, rv_hs);
        check("single_rvalid_hs", rv_hs, 0);
        check("single_rvalid_lat", bus.RVALID, 1);
        rexp[0] = pat(100);
        r_recv(1, 1'b0, 2'd1, "single");

        // 16-beat INCR burst
        for (int i = 0; i < 16; i++) begin wbuf[i] = pat(i); rexp[i] = pat(i); end
        aw_send(2'd1, 32'h0, 8'd15);
        w_burst(16, 15);
        b_recv(2'd1, 2'b00, "burst");
        ar_send(2'd3, 32'h0, 8'd15, rv_hs);
        r_recv(16, 1'b0, 2'd3, "burst");

        // same read under RREADY backpressure
        ar_send(2'd0, 32'h0, 8'd15, rv_hs);
        r_recv(16, 1'b1, 2'd0, "bp");

        // byte strobe
        wbuf[0] = '1;
        aw_send(2'd0, 32'h400, 8'd0);
        w_burst(1, 0);
        b_recv(2'd0, 2'b00, "strb_a");
        wbuf[0] = '0; sbuf[0] = 64'h1;
        aw_send(2'd0, 32'h400, 8'd0);
        w_burst(1, 0);
        b_recv(2'd0, 2'b00, "strb_b");
        sbuf[0] = '1;
        rexp[0] = {{(DW-8){1'b1}}, 8'h00};
        ar_send(2'd2, 32'h400, 8'd0, rv_hs);
        r_recv(1, 1'b0, 2'd2, "strb");

        // W before AW stalls
        bus.WDATA = pat(50); bus.WSTRB = '1; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("early_w_wready%0d", i), bus.WREADY, 0);
            @(negedge CLK);
        end
        aw_send(2'd1, 32'h800, 8'd0);
        wbuf[0] = pat(50);
        w_burst(1, 0);
        b_recv(2'd1, 2'b00, "early_w");
        rexp[0] = pat(50);
        ar_send(2'd1, 32'h800, 8'd0, rv_hs);
        r_recv(1, 1'b0, 2'd1, "early_w");

        // len 3 with WLAST on the second beat
        wbuf[0] = pat(60); wbuf[1] = pat(61);
        aw_send(2'd3, 32'hC00, 8'd3);
        w_burst(2, 1);
        b_recv(2'd3, 2'b10, "short");

        // wrap past the top row
        wbuf[0] = pat(200); wbuf[1] = pat(201);
        aw_send(2'd2, 32'h0000_FFC0, 8'd1);
        w_burst(2, 1);
`ifdef AXI4_SRAM_RANGE_CHECK_EN
        b_recv(2'd2, 2'b10, "wrap");
        rexp[0] = pat(0);
`else
        b_recv(2'd2, 2'b00, "wrap");
        rexp[0] = pat(201);
`endif
        ar_send(2'd0, 32'h0, 8'd0, rv_hs);
        r_recv(1, 1'b0, 2'd0, "wrap_row0");
        rexp[0] = pat(200);
`ifdef AXI4_SRAM_RANGE_CHECK_EN
        rexp[1] = '0;     rrexp[1] = 2'b10;
`else
        rexp[1] = pat(201); rrexp[1] = 2'b00;
`endif
        ar_send(2'd0, 32'h0000_FFC0, 8'd1, rv_hs);
        r_recv(2, 1'b0, 2'd0, "wrap_top");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
